// File: rtl/icache_pkg.sv
// Shared configuration, derived field widths and FSM encoding for the instruction cache.
package icache_pkg;
  localparam int NUM_SETS        = 8;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int ADDR_W          = 10;

  localparam int OFFSET_W   = $clog2(WORDS_PER_BLOCK);
  localparam int INDEX_W    = $clog2(NUM_SETS);
  localparam int TAG_W      = ADDR_W - 2 - OFFSET_W - INDEX_W;
  localparam int MEM_ADDR_W = TAG_W + INDEX_W;
  localparam int BLOCK_W    = 32 * WORDS_PER_BLOCK;

  // Word 0 of a block sits in bits [31:0], matching the memory bus layout.
  typedef logic [WORDS_PER_BLOCK-1:0][31:0] block_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_READ,
    S_UPDATE
  } state_e;
endpackage

// File: rtl/icache_store.sv
// Valid/tag/data arrays of the direct-mapped cache: combinational hit and word
// select on the read side, synchronous block and tag writes from the refill FSM.
module icache_store
  import icache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [TAG_W-1:0]    rd_tag,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic                hit,
  output logic [31:0]         rd_word,
  input  logic                data_we,
  input  logic                tag_we,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]    wr_tag,
  input  block_t              wr_block
);
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  block_t              data_mem [NUM_SETS];

  always_comb begin
    valid_d = valid_q;
    if (tag_we) valid_d[wr_index] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // NOTE: the arrays are left unreset on purpose; a cleared valid bit already
  // hides whatever they hold, and a reset would stop them mapping onto RAM.
  always_ff @(posedge CLK) begin
    if (data_we) data_mem[wr_index] <= wr_block;
    if (tag_we)  tag_mem[wr_index]  <= wr_tag;
  end

  assign hit     = valid_q[rd_index] && (tag_mem[rd_index] == rd_tag);
  assign rd_word = data_mem[rd_index][rd_offset];
endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with a three-state block refill FSM.
// Optional hit/miss counters are compiled in with ICACHE_STATS_EN.
module instr_cache
  import icache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           PC,
  output logic [31:0]           INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           HIT_COUNT,
  output logic [31:0]           MISS_COUNT
`endif
);
  state_e              state_q, state_d;
  logic [INDEX_W-1:0]  miss_index_q, miss_index_d;
  logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
  logic [31:0]         instr_q, instr_d;

  logic [OFFSET_W-1:0] pc_offset;
  logic [INDEX_W-1:0]  pc_index;
  logic [TAG_W-1:0]    pc_tag;
  logic                pc_valid;
  logic                hit;
  logic [31:0]         rd_word;
  logic                data_we, tag_we;
  logic                unused_pc_bits;

  assign pc_offset      = PC[OFFSET_W+1:2];
  assign pc_index       = PC[INDEX_W+OFFSET_W+1:OFFSET_W+2];
  assign pc_tag         = PC[ADDR_W-1:ADDR_W-TAG_W];
  assign unused_pc_bits = ^PC[1:0];
  // The CPU parks its PC at 0xFFFFFFFC before starting; anything above ADDR_W is not a fetch.
  assign pc_valid       = !RESET && (PC[31:ADDR_W] == '0);

  icache_store u_store (
    .CLK      (CLK),
    .RESET    (RESET),
    .rd_index (pc_index),
    .rd_tag   (pc_tag),
    .rd_offset(pc_offset),
    .hit      (hit),
    .rd_word  (rd_word),
    .data_we  (data_we),
    .tag_we   (tag_we),
    .wr_index (miss_index_q),
    .wr_tag   (miss_tag_q),
    .wr_block (MEM_READDATA)
  );

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    state_d      = state_q;
    miss_index_d = miss_index_q;
    miss_tag_d   = miss_tag_q;
    instr_d      = instr_q;
    INSTRUCTION  = instr_q;
    BUSYWAIT     = 1'b0;
    MEM_READ     = 1'b0;
    MEM_ADDRESS  = '0;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pc_valid) begin
          if (hit) begin
            INSTRUCTION = rd_word;
            instr_d     = rd_word;
          end else begin
            BUSYWAIT     = 1'b1;
            miss_index_d = pc_index;
            miss_tag_d   = pc_tag;
            state_d      = S_MEM_READ;
          end
        end
      end
      S_MEM_READ: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {miss_tag_q, miss_index_q};
        BUSYWAIT    = 1'b1;
        if (!MEM_BUSYWAIT) begin
          data_we = 1'b1;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        BUSYWAIT = 1'b1;
        tag_we   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      miss_index_q <= '0;
      miss_tag_q   <= '0;
      instr_q      <= '0;
    end else begin
      state_q      <= state_d;
      miss_index_q <= miss_index_d;
      miss_tag_q   <= miss_tag_d;
      instr_q      <= instr_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == S_IDLE && pc_valid) begin
      if (hit && hit_count_q != '1)    hit_count_d  = hit_count_q + 32'd1;
      if (!hit && miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif
endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: a driver issues fetches and queues the expected
// word and stall length from a set-level cache model; a monitor checks each completion.
module tb_instr_cache;
  localparam int NSETS = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    int          stall;
    int          mr;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [31:0]  PC = 32'hFFFF_FFFC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA = '0;
  logic         MEM_BUSYWAIT = 1'b1;
`ifdef ICACHE_STATS_EN
  logic [31:0]  HIT_COUNT, MISS_COUNT;
`endif

  instr_cache dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .INSTRUCTION (INSTRUCTION),
    .BUSYWAIT    (BUSYWAIT),
    .MEM_READ    (MEM_READ),
    .MEM_ADDRESS (MEM_ADDRESS),
    .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT   (HIT_COUNT),
    .MISS_COUNT  (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] imem [256];
  bit          mv [NSETS];
  int          mt [NSETS];
  exp_t        exp_q [$];
  int          lat = 5;
  int          mr_k = 0;
  bit          mon_en = 1'b1;
  int          stall = 0;
  int          mrc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Instruction memory: MEM_BUSYWAIT drops on the lat-th cycle of a request, with the block valid then.
  always @(posedge CLK) begin
    #1;
    if (MEM_READ) begin
      mr_k++;
      MEM_BUSYWAIT = (mr_k < lat);
      if (mr_k >= lat) begin
        for (int w = 0; w < 4; w++) MEM_READDATA[w*32 +: 32] = imem[int'(MEM_ADDRESS) * 4 + w];
      end else begin
        MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
      end
    end else begin
      mr_k = 0;
      MEM_BUSYWAIT = 1'b1;
      MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Monitor: counts stall cycles of the oldest request and checks it when BUSYWAIT drops.
  always @(negedge CLK) begin
    if (mon_en && !RESET && exp_q.size() > 0) begin
      if (BUSYWAIT) begin
        stall++;
        if (MEM_READ) begin
          if (mrc == 0) check("mem_address", 32'(MEM_ADDRESS), (exp_q[0].pc >> 4) & 32'h3F);
          mrc++;
        end
        if (stall > 100) begin
          n_tests++;
          n_fail++;
          $display("FAIL stall_timeout: pc 0x%08h still busy after %0d cycles, expected %0d", exp_q[0].pc, stall, exp_q[0].stall);
          void'(exp_q.pop_front());
          stall = 0;
          mrc = 0;
        end
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("instruction", INSTRUCTION, e.word);
        check("stall_cycles", 32'(stall), 32'(e.stall));
        check("mem_read_cycles", 32'(mrc), 32'(e.mr));
        stall = 0;
        mrc = 0;
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < NSETS; i++) begin
      mv[i] = 1'b0;
      mt[i] = 0;
    end
  endtask

  // Issue one fetch; a miss in the model costs memory latency + 2 stall cycles.
  task automatic issue(input logic [31:0] pc, input int lat_req);
    exp_t e;
    int   set_i, tag_i;
    bit   miss;
    set_i = int'((pc / 16) % NSETS);
    tag_i = int'((pc / 128) % 8);
    miss  = !mv[set_i] || (mt[set_i] != tag_i);
    @(posedge CLK);
    #1;
    lat     = (lat_req > 0) ? lat_req : int'($urandom_range(1, 6));
    e.pc    = pc;
    e.word  = imem[(pc / 4) % 256];
    e.stall = miss ? lat + 2 : 0;
    e.mr    = miss ? lat : 0;
    mv[set_i] = 1'b1;
    mt[set_i] = tag_i;
    exp_q.push_back(e);
    PC = pc;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      @(negedge CLK);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: pc 0x%08h not completed, %0d requests pending", pc, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic idle_checks(input string tag, input logic [31:0] instr_exp);
    check({tag, "_busywait"}, 32'(BUSYWAIT), 32'd0);
    check({tag, "_mem_read"}, 32'(MEM_READ), 32'd0);
    check({tag, "_mem_address"}, 32'(MEM_ADDRESS), 32'd0);
    check({tag, "_instruction"}, INSTRUCTION, instr_exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0] = 32'h11;
    imem[1] = 32'h22;
    imem[2] = 32'h33;
    imem[3] = 32'h44;
    clear_model();

    // Reset state, then parked PC after release.
    repeat (2) @(negedge CLK);
    idle_checks("in_reset", 32'h0);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    idle_checks("parked_pc", 32'h0);

    // Cold miss with 5-cycle memory, then hits on the rest of the block.
    issue(32'h000, 5);
    issue(32'h004, 0);
    issue(32'h008, 0);
    issue(32'h00C, 0);
    @(posedge CLK);
    #1;
    PC = 32'hFFFF_FFFC;
`ifdef ICACHE_STATS_EN
    @(negedge CLK);
    check("miss_count", MISS_COUNT, 32'd1);
    check("hit_count", HIT_COUNT, 32'd4);
`endif
    repeat (3) @(negedge CLK);
    idle_checks("hold_after_hit", 32'h44);

    // Conflict miss on set 0 with tag 1, then the original line misses again.
    issue(32'h080, 3);
    issue(32'h000, 4);
    issue(32'h00C, 0);

    // Asynchronous reset on the third MEM_READ cycle of a refill.
    mon_en = 1'b0;
    @(posedge CLK);
    #1;
    lat = 6;
    PC  = 32'h100;
    begin : wait_refill
      int k;
      k = 0;
      for (int c = 0; c < 50 && k < 3; c++) begin
        @(negedge CLK);
        if (MEM_READ) k++;
      end
      check("refill_reached_cycle3", 32'(k), 32'd3);
    end
    #2;
    RESET = 1'b1;
    PC    = 32'hFFFF_FFFC;
    #1;
    idle_checks("async_reset", 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    clear_model();
    mon_en = 1'b1;
    issue(32'h000, 4);
    issue(32'h100, 2);

    // Randomized traffic, biased toward a small region so hits and conflicts both occur.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] pc;
      pc = $urandom_range(0, 1) ? 32'($urandom_range(0, 127)) : 32'($urandom_range(0, 1023));
      issue(pc, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port and the instruction memory.
- CPU side: receives PC; returns INSTRUCTION and BUSYWAIT.
- Memory side: runs a block refill on a miss, with a level handshake against a multi-cycle instruction memory.
- Responder to the CPU fetch path; CPU stalls its PC while BUSYWAIT is high.

Parameters:
- NUM_SETS, 8, number of cache blocks (power of two).
- WORDS_PER_BLOCK, 4, 32-bit words per block (power of two).
- ADDR_W, 10, significant PC bits; upper PC bits are ignored.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- PC  input  32  fetch address from CPU, word aligned.
- INSTRUCTION  output  32  fetched instruction word.
- BUSYWAIT  output  1  high while the requested word is not available.
- MEM_READ  output  1  refill request to instruction memory.
- MEM_ADDRESS  output  ADDR_W-4  block address (PC[9:4] at defaults).
- MEM_READDATA  input  32*WORDS_PER_BLOCK  refill block; word 0 in bits [31:0].
- MEM_BUSYWAIT  input  1  memory busy; data valid on the cycle it drops.

Behaviour:
- Address split at defaults:
  - offset = PC[3:2]
  - index = PC[6:4]
  - tag = PC[9:7] (3 bits)
  - PC[1:0] ignored.
- Storage: per set one valid bit, one tag, one block. Data/tag arrays are not reset. Valid bits clear to 0 on RESET.
- Hit detection is combinational: hit = valid[index] && tag[index]==tag.
  - On a hit in IDLE: INSTRUCTION = block word[offset] and BUSYWAIT=0 in the same cycle. Zero-cycle hit latency.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE: if PC is valid and there is no hit, BUSYWAIT=1 combinationally; next state MEM_READ. The index and tag are latched at this edge.
  - MEM_READ: MEM_READ=1, MEM_ADDRESS={latched tag, latched index}, BUSYWAIT=1. Stay while MEM_BUSYWAIT=1. On the edge where MEM_BUSYWAIT=0, capture MEM_READDATA into data[latched index]. Next state UPDATE.
  - UPDATE: write tag, set valid, BUSYWAIT=1, MEM_READ=0. Next state IDLE. The following cycle hits.
- Miss penalty = memory latency + 2 cycles.
- INSTRUCTION is held at its last hit value while BUSYWAIT=1.
- MEM_READ is 0 and MEM_ADDRESS is 0 outside MEM_READ.
- PC-valid qualifier: when RESET=1, or PC[31:ADDR_W] != 0 (CPU pre-start value 0xFFFFFFFC), BUSYWAIT=0 and no refill starts.
- PC change during refill is a protocol violation. The refill completes for the latched address, then the new PC is evaluated in IDLE.
- Conflict miss: the same index with a different tag overwrites the block. No write-back is needed (read-only).
- RESET asserted mid-refill, asynchronously:
  - state -> IDLE, MEM_READ=0, BUSYWAIT=0, INSTRUCTION=0, all valid bits=0.
  - Partial refill data is discarded.
- Reset values: INSTRUCTION=0, BUSYWAIT=0, MEM_READ=0, MEM_ADDRESS=0, state IDLE.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined:
  - Adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0].
  - HIT_COUNT increments once per cycle in IDLE with a valid PC and a hit while the CPU advances.
  - MISS_COUNT increments once per IDLE->MEM_READ transition.
  - Both counters saturate at 0xFFFFFFFF and clear on RESET.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package icache_pkg:
  - TAG_W, INDEX_W, OFFSET_W derived from the parameters.
  - State enum {IDLE, MEM_READ, UPDATE}.
  - BLOCK_W = 32*WORDS_PER_BLOCK.
- One sub-module, icache_store:
  - Holds the valid/tag/data arrays.
  - Provides the combinational hit compare and word select.
  - Synchronous write port driven by the FSM.
- The FSM stays in instr_cache.

Test Plan:
- Reset then PC=0xFFFFFFFC -> BUSYWAIT=0, MEM_READ=0, INSTRUCTION=0.
- Cold miss: PC=0x000, memory latency 5 cycles, block {0x44,0x33,0x22,0x11} -> MEM_READ=1 with MEM_ADDRESS=0 for 5 cycles; BUSYWAIT high 7 cycles; then INSTRUCTION=0x11, BUSYWAIT=0.
- Hits after fill: PC=0x004, 0x008, 0x00C -> INSTRUCTION=0x22, 0x33, 0x44 with BUSYWAIT=0 the same cycle; MEM_READ stays 0.
- Conflict: PC=0x080 (same index 0, tag 1) -> refill with MEM_ADDRESS=0x08; a later PC=0x000 misses again.
- RESET pulse on cycle 3 of a refill -> MEM_READ and BUSYWAIT drop immediately; after release, PC=0x000 misses (valid cleared).
- With ICACHE_STATS_EN: cold miss + 3 hits -> MISS_COUNT=1, HIT_COUNT=4 (including the post-fill hit).
